code_entry_sequencer: RTL

//  Command initiator for the lock's code checker. Turns raw active-low push buttons and the
//  2-bit symbol switches into clean single-cycle input_value/store_value/compare/input_reset

---
 rtl/code_entry_sequencer_pkg.sv | 31 +++
 rtl/code_entry_sequencer_key_debouncer.sv | 42 ++++
 rtl/code_entry_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/code_entry_sequencer_pkg.sv
// Shared lock definitions: FSM encoding, password length
// and debounce defaults used across the lock blocks.
package code_entry_sequencer_pkg;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_COLLECT_IN = 3'd1;
  localparam logic [2:0] ST_COLLECT_ST = 3'd2;
  localparam logic [2:0] ST_FULL_IN    = 3'd3;
  localparam logic [2:0] ST_FULL_ST    = 3'd4;
  localparam logic [2:0] ST_CLEAR      = 3'd5;

  localparam int unsigned PW_LEN_DEF   = 4;
  localparam int unsigned DEBOUNCE_DEF = 1_000_000;

  typedef enum logic [2:0] {
    IDLE       = ST_IDLE,
    COLLECT_IN = ST_COLLECT_IN,
    COLLECT_ST = ST_COLLECT_ST,
    FULL_IN    = ST_FULL_IN,
    FULL_ST    = ST_FULL_ST,
    CLEAR      = ST_CLEAR
  } state_t;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_IN,
    EV_ST,
    EV_SUB
  } ev_t;

endpackage

// File: rtl/code_entry_sequencer_key_debouncer.sv
// Button synchroniser and debouncer; emits a one-cycle
// pulse when the debounced level falls (key pressed).
module key_debouncer
  import code_entry_sequencer_pkg::*;
#(
  parameter int unsigned CYCLES = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [1:0]    sync;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], key_n};
      press <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt   <= '0;
        level <= sync[1];
        press <= ~sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/code_entry_sequencer.sv
// Turns debounced lock buttons into single-cycle checker
// strobes, counting symbols so only whole codes are sent.
module code_entry_sequencer
  import code_entry_sequencer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int unsigned PW_LEN          = PW_LEN_DEF
) (
  input  logic       clk,
  input  logic       system_reset_n,
  input  logic       key_store_n,
  input  logic       key_input_n,
  input  logic       key_submit_n,
  input  logic [1:0] sym_in,
  output logic [1:0] bits,
  output logic       input_value,
  output logic       store_value,
  output logic       compare,
  output logic       input_reset,
  output logic [1:0] digit_idx,
  output logic       entry_full
);

  localparam logic [2:0] PW = 3'(PW_LEN);

  logic   p_st, p_in, p_sub;
  ev_t    ev;
  state_t state, state_n;
  logic [2:0] cnt, cnt_n, cnt_inc;
  logic [1:0] bits_n;
  logic iv_n, sv_n, cmp_n, ir_n;

  key_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_db_st (
    .clk(clk), .rst_n(system_reset_n),
    .key_n(key_store_n), .press(p_st));

  key_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_db_in (
    .clk(clk), .rst_n(system_reset_n),
    .key_n(key_input_n), .press(p_in));

  key_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_db_sub (
    .clk(clk), .rst_n(system_reset_n),
    .key_n(key_submit_n), .press(p_sub));

  always_comb begin
    ev = EV_NONE;
    priority case (1'b1)
      p_sub:   ev = EV_SUB;
      p_st:    ev = EV_ST;
      p_in:    ev = EV_IN;
      default: ev = EV_NONE;
    endcase
  end

  assign cnt_inc = cnt + 3'd1;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bits_n  = bits;
    iv_n    = 1'b0;
    sv_n    = 1'b0;
    cmp_n   = 1'b0;
    ir_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (ev == EV_IN) begin
          iv_n    = 1'b1;
          bits_n  = sym_in;
          cnt_n   = 3'd1;
          state_n = (PW == 3'd1) ? FULL_IN : COLLECT_IN;
        end else if (ev == EV_ST) begin
          sv_n    = 1'b1;
          bits_n  = sym_in;
          cnt_n   = 3'd1;
          state_n = (PW == 3'd1) ? FULL_ST : COLLECT_ST;
        end
      end
      COLLECT_IN: begin
        if (ev == EV_SUB) begin
          state_n = CLEAR;
        end else if (ev == EV_IN) begin
          iv_n    = 1'b1;
          bits_n  = sym_in;
          cnt_n   = cnt_inc;
          state_n = (cnt_inc == PW) ? FULL_IN : COLLECT_IN;
        end
      end
      COLLECT_ST: begin
        if (ev == EV_SUB) begin
          state_n = CLEAR;
        end else if (ev == EV_ST) begin
          sv_n    = 1'b1;
          bits_n  = sym_in;
          cnt_n   = cnt_inc;
          state_n = (cnt_inc == PW) ? FULL_ST : COLLECT_ST;
        end
      end
      FULL_IN: begin
        if (ev == EV_SUB) begin
          cmp_n   = 1'b1;
          state_n = CLEAR;
        end
      end
      FULL_ST: begin
        if (ev == EV_SUB) begin
          cnt_n   = 3'd0;
          state_n = IDLE;
        end
      end
      CLEAR: begin
        ir_n    = 1'b1;
        cnt_n   = 3'd0;
        state_n = IDLE;
      end
      default: begin
        cnt_n   = 3'd0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      bits        <= 2'b00;
      input_value <= 1'b0;
      store_value <= 1'b0;
      compare     <= 1'b0;
      input_reset <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bits        <= bits_n;
      input_value <= iv_n;
      store_value <= sv_n;
      compare     <= cmp_n;
      input_reset <= ir_n;
    end
  end

  // A full 4-symbol count shows as 0 on the 2-bit port; entry_full tells it apart.
  assign digit_idx  = cnt[1:0];
  assign entry_full = (cnt == PW);

endmodule
